// File: rtl/fp_unpack_norm_pkg.sv
// Shared types and constants for the FPU operand unpacker.
// State encoding, format limits and significand geometry.
package fpu_unpack_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_DONE
    } state_t;

    localparam logic [10:0] EMAX_DB = 11'h7FF;
    localparam logic [7:0]  EMAX_SP = 8'hFF;
    localparam logic [10:0] EMIN    = 11'd1;
    localparam int          FA_W    = 53;
    localparam int          SP_PAD  = 29;

endpackage

// File: rtl/fp_unpack_norm_if.sv
// Operand-in / result-out handshake bundle for fp_unpack_norm.
// master drives operands and accepts results; slave is the unpacker.
interface fp_unpack_norm_if #(
    parameter int N = 10
);
    logic        in_valid;
    logic        in_ready;
    logic [63:0] fp_in;
    logic        db;
    logic        out_valid;
    logic        out_ready;
    logic        sa;
    logic [N:0]  ea;
    logic [52:0] fa;
    logic [5:0]  lz;
    logic        zero;
    logic        inf;
    logic        nan;
    logic        snan;
    logic        denorm;

    modport master (
        output in_valid, fp_in, db, out_ready,
        input  in_ready, out_valid, sa, ea, fa, lz,
        input  zero, inf, nan, snan, denorm
    );

    modport slave (
        input  in_valid, fp_in, db, out_ready,
        output in_ready, out_valid, sa, ea, fa, lz,
        output zero, inf, nan, snan, denorm
    );
endinterface

// File: rtl/fp_unpack_norm_classify.sv
// Field extraction and class decode for a packed double/single operand.
// Single fields are widened to the double layout before classification.
module fp_classify
    import fpu_unpack_pkg::*;
#(
    parameter int N = 10
) (
    input  logic [63:0] i_fp_in,
    input  logic        i_db,
    output logic [N:0]  o_e,
    output logic [51:0] o_f,
    output logic        o_zero,
    output logic        o_inf,
    output logic        o_nan,
    output logic        o_snan,
    output logic        o_denorm
);
    logic w_emax;
    logic w_ezero;
    logic w_fnz;

    // Map fields to double width and flag an all-ones exponent.
    always_comb begin
        o_e    = '0;
        o_f    = '0;
        w_emax = 1'b0;
        if (i_db) begin
            o_e    = i_fp_in[62:52];
            o_f    = i_fp_in[51:0];
            w_emax = (i_fp_in[62:52] == EMAX_DB);
        end else begin
            o_e    = {{(N-7){1'b0}}, i_fp_in[30:23]};
            o_f    = {i_fp_in[22:0], {SP_PAD{1'b0}}};
            w_emax = (i_fp_in[30:23] == EMAX_SP);
        end
    end

    assign w_ezero  = (o_e == '0);
    assign w_fnz    = |o_f;
    assign o_zero   = w_ezero & ~w_fnz;
    assign o_denorm = w_ezero & w_fnz;
    assign o_inf    = w_emax & ~w_fnz;
    assign o_nan    = w_emax & w_fnz;
    assign o_snan   = o_nan & ~o_f[51];
endmodule

// File: rtl/fp_unpack_norm.sv
// Multi-cycle operand unpacker: classify, then left-normalize denormals
// by STEP or 1 bit per cycle, counting the shift in lz.
module fp_unpack_norm
    import fpu_unpack_pkg::*;
#(
    parameter int N    = 10,
    parameter int STEP = 8
) (
    input logic           clk,
    input logic           rst_n,
    fp_unpack_norm_if.slave bus
);
    state_t          r_state;
    state_t          w_next;
    logic            r_sa;
    logic [N:0]      r_ea;
    logic [FA_W-1:0] r_fa;
    logic [5:0]      r_lz;
    logic            r_zero;
    logic            r_inf;
    logic            r_nan;
    logic            r_snan;
    logic            r_denorm;

    logic [N:0]      w_e;
    logic [51:0]     w_f;
    logic            w_zero;
    logic            w_inf;
    logic            w_nan;
    logic            w_snan;
    logic            w_denorm;
    logic            w_accept;
    logic            w_stop;
    logic            w_coarse;

    fp_classify #(
        .N (N)
    ) u_cls (
        .i_fp_in  (bus.fp_in),
        .i_db     (bus.db),
        .o_e      (w_e),
        .o_f      (w_f),
        .o_zero   (w_zero),
        .o_inf    (w_inf),
        .o_nan    (w_nan),
        .o_snan   (w_snan),
        .o_denorm (w_denorm)
    );

    assign w_accept = bus.in_valid & (r_state == S_IDLE);
    assign w_stop   = r_fa[FA_W-1] | r_zero | r_inf | r_nan;
    assign w_coarse = ~|r_fa[FA_W-1 -: STEP];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: accept, normalize until leading one, hold until taken.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (w_accept)      w_next = S_NORM;
            S_NORM:  if (w_stop)        w_next = S_DONE;
            S_DONE:  if (bus.out_ready) w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    // Operand load on accept, then shift/count while normalizing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sa     <= 1'b0;
            r_ea     <= '0;
            r_fa     <= '0;
            r_lz     <= '0;
            r_zero   <= 1'b0;
            r_inf    <= 1'b0;
            r_nan    <= 1'b0;
            r_snan   <= 1'b0;
            r_denorm <= 1'b0;
        end else if (w_accept) begin
            r_sa     <= bus.db ? bus.fp_in[63] : bus.fp_in[31];
            r_lz     <= '0;
            r_zero   <= w_zero;
            r_inf    <= w_inf;
            r_nan    <= w_nan;
            r_snan   <= w_snan;
            r_denorm <= w_denorm;
            unique case (1'b1)
                w_zero: begin
                    r_ea <= '0;
                    r_fa <= '0;
                end
                w_denorm: begin
                    r_ea <= EMIN;
                    r_fa <= {1'b0, w_f};
                end
                default: begin
                    r_ea <= w_e;
                    r_fa <= {1'b1, w_f};
                end
            endcase
        end else if (r_state == S_NORM && !w_stop) begin
            if (w_coarse) begin
                r_fa <= r_fa << STEP;
                r_lz <= r_lz + 6'(STEP);
            end else begin
                r_fa <= r_fa << 1;
                r_lz <= r_lz + 6'd1;
            end
        end
    end

    assign bus.in_ready  = (r_state == S_IDLE);
    assign bus.out_valid = (r_state == S_DONE);
    assign bus.sa        = r_sa;
    assign bus.ea        = r_ea;
    assign bus.fa        = r_fa;
    assign bus.lz        = r_lz;
    assign bus.zero      = r_zero;
    assign bus.inf       = r_inf;
    assign bus.nan       = r_nan;
    assign bus.snan      = r_snan;
    assign bus.denorm    = r_denorm;
endmodule

// File: tb/tb_fp_unpack_norm.sv
// Scoreboard bench for fp_unpack_norm: directed operands, expected
// results queued at accept and checked by a monitor at output handshake.
module tb_fp_unpack_norm;
    import fpu_unpack_pkg::*;

    typedef struct {
        logic        sa;
        logic [10:0] ea;
        logic [52:0] fa;
        logic [5:0]  lz;
        logic [4:0]  fl;
        int          lat;
        int          k;
        string       nm;
    } exp_t;

    localparam logic [52:0] H = 53'h10_0000_0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_out = 0;
    int   n_push = 0;
    int   last_k = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fp_unpack_norm_if #(.N(10)) bus ();

    fp_unpack_norm #(
        .N    (10),
        .STEP (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    task automatic fail_now(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s", nm);
    endtask

    function automatic exp_t mk(input logic s, input logic [10:0] e,
                                input logic [52:0] f, input logic [5:0] l,
                                input logic [4:0] fl, input int lat,
                                input string nm);
        exp_t x;
        x.sa  = s;
        x.ea  = e;
        x.fa  = f;
        x.lz  = l;
        x.fl  = fl;
        x.lat = lat;
        x.k   = 0;
        x.nm  = nm;
        return x;
    endfunction

    function automatic logic [4:0] flags();
        return {bus.zero, bus.inf, bus.nan, bus.snan, bus.denorm};
    endfunction

    // Monitor: track first valid cycle, compare on output handshake.
    logic seen = 1'b0;
    int   first = 0;
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst_n) begin
            seen = 1'b0;
        end else if (bus.out_valid) begin
            if (!seen) begin
                seen  = 1'b1;
                first = cyc;
            end
            if (bus.out_ready) begin
                n_out++;
                seen = 1'b0;
                if (sbq.size() == 0) begin
                    fail_now("unexpected_output");
                end else begin
                    e = sbq.pop_front();
                    chk({e.nm, ".sa"}, 64'(bus.sa), 64'(e.sa));
                    chk({e.nm, ".ea"}, 64'(bus.ea), 64'(e.ea));
                    chk({e.nm, ".fa"}, 64'(bus.fa), 64'(e.fa));
                    chk({e.nm, ".lz"}, 64'(bus.lz), 64'(e.lz));
                    chk({e.nm, ".flags"}, 64'(flags()), 64'(e.fl));
                    chk({e.nm, ".lat"}, 64'(first + 1 - e.k), 64'(e.lat));
                end
            end
        end
    end

    task automatic send(input logic [63:0] fp, input logic d,
                        input exp_t ex, input bit push);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) begin
            fail_now({ex.nm, ".in_ready_timeout"});
            return;
        end
        bus.fp_in    = fp;
        bus.db       = d;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        ex.k   = cyc;
        last_k = cyc;
        if (push) begin
            sbq.push_back(ex);
            n_push++;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input string nm);
        int t;
        t = 0;
        while ((sbq.size() != 0 || !bus.in_ready) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) fail_now({nm, ".drain_timeout"});
    endtask

    task automatic chk_reset_state(input string nm);
        chk({nm, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        chk({nm, ".out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({nm, ".sa"}, 64'(bus.sa), 64'd0);
        chk({nm, ".ea"}, 64'(bus.ea), 64'd0);
        chk({nm, ".fa"}, 64'(bus.fa), 64'd0);
        chk({nm, ".lz"}, 64'(bus.lz), 64'd0);
        chk({nm, ".flags"}, 64'(flags()), 64'd0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int t;
        bus.in_valid  = 1'b0;
        bus.fp_in     = '0;
        bus.db        = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk_reset_state("reset");
        rst_n = 1'b1;

        send(64'h3FF0_0000_0000_0000, 1'b1,
             mk(0, 11'h3FF, H, 6'd0, 5'b00000, 2, "d_one"), 1);
        send(64'h0000_0000_0000_0001, 1'b1,
             mk(0, 11'd1, H, 6'd52, 5'b00001, 12, "d_mindn"), 1);
        send({32'hDEAD_BEEF, 32'h0000_0001}, 1'b0,
             mk(0, 11'd1, H, 6'd23, 5'b00001, 11, "s_mindn"), 1);
        send({32'h0, 32'h7F80_0001}, 1'b0,
             mk(0, 11'h0FF, H | (53'd1 << 29), 6'd0, 5'b00110, 2,
                "s_snan"), 1);
        send({32'h0, 32'h7FC0_0000}, 1'b0,
             mk(0, 11'h0FF, H | (53'd1 << 51), 6'd0, 5'b00100, 2,
                "s_qnan"), 1);
        send(64'h7FF0_0000_0000_0000, 1'b1,
             mk(0, 11'h7FF, H, 6'd0, 5'b01000, 2, "d_inf"), 1);
        send(64'hC000_0000_0000_0000, 1'b1,
             mk(1, 11'h400, H, 6'd0, 5'b00000, 2, "d_m2"), 1);
        send(64'h0008_0000_0000_0000, 1'b1,
             mk(0, 11'd1, H, 6'd1, 5'b00001, 3, "d_dn_b51"), 1);
        send(64'h0000_1000_0000_0000, 1'b1,
             mk(0, 11'd1, H, 6'd8, 5'b00001, 3, "d_dn_b44"), 1);
        send({32'h0, 32'h3F80_0000}, 1'b0,
             mk(0, 11'h07F, H, 6'd0, 5'b00000, 2, "s_one"), 1);
        send({32'h0, 32'h0040_0000}, 1'b0,
             mk(0, 11'd1, H, 6'd1, 5'b00001, 3, "s_dn_b22"), 1);
        drain("vectors");

        bus.out_ready = 1'b0;
        send(64'h8000_0000_0000_0000, 1'b1,
             mk(1, 11'd0, 53'd0, 6'd0, 5'b10000, 2, "d_negz"), 1);
        t = 0;
        while (!bus.out_valid && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.out_valid) fail_now("negz.valid_timeout");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall.out_valid", 64'(bus.out_valid), 64'd1);
            chk("stall.in_ready", 64'(bus.in_ready), 64'd0);
            chk("stall.sa", 64'(bus.sa), 64'd1);
            chk("stall.zero", 64'(bus.zero), 64'd1);
            chk("stall.fa", 64'(bus.fa), 64'd0);
            bus.fp_in    = 64'h3FF0_0000_0000_0000;
            bus.db       = 1'b1;
            bus.in_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("release.in_ready_before", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        chk("release.in_ready_after", 64'(bus.in_ready), 64'd1);
        drain("stall");

        send(64'h0000_0000_0000_0001, 1'b1,
             mk(0, 11'd1, H, 6'd52, 5'b00001, 12, "abort"), 0);
        while (cyc < last_k + 4) begin
            @(posedge clk);
            #1;
        end
        chk("abort.busy", 64'(bus.in_ready), 64'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_reset_state("abort_rst");
        @(negedge clk);
        rst_n = 1'b1;
        send(64'h3FF0_0000_0000_0000, 1'b1,
             mk(0, 11'h3FF, H, 6'd0, 5'b00000, 2, "post_rst"), 1);
        drain("post_rst");

        repeat (4) @(negedge clk);
        chk("output_count", 64'(n_out), 64'(n_push));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/fp_unpack_norm.md
# fp_unpack_norm

Multi-cycle operand unpacker for the FPU datapath. It takes a packed IEEE-754 double or single operand, classifies it, and emits sign, biased exponent, and a significand normalized so that its MSB is set. It also emits the leading-zero count `lz`. `lz` is the same quantity the rounder's exponent normalizer consumes on the result side, so this block is the operand-side counterpart of that path. Denormals are normalized iteratively, up to 8 bits per cycle, behind a valid/ready handshake.

## Interface
Parameters:
- `N`, 10: exponent MSB index; the exponent is `N+1` = 11 bits wide.
- `STEP`, 8: coarse shift distance per normalization cycle.

Ports:
- `clk` in 1: single clock, all state on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand valid.
- `in_ready` out 1: block can accept an operand. High only in IDLE.
- `fp_in` in 64: packed operand. When `db`=0, single precision in `fp_in[31:0]` and `[63:32]` is ignored.
- `db` in 1: 1 = double, 0 = single. Sampled at accept.
- `out_valid` out 1: result valid. Held until accepted.
- `out_ready` in 1: consumer accepts result.
- `sa` out 1: sign.
- `ea` out 11: biased exponent. A single-precision exponent is zero-extended.
- `fa` out 53: significand, `fa[52]` is the hidden/leading bit.
- `lz` out 6: left-shift amount applied to `fa`.
- `zero`, `inf`, `nan`, `snan`, `denorm` out 1 each: class flags. `snan` implies `nan`.

## Operation
- States: IDLE, NORM, DONE (state encoding lives in the package).
- IDLE: `in_ready`=1. On `in_valid & in_ready`, capture `db`, decode via `fp_classify`, load registers, and go to NORM.
- Field mapping:
  - Double: `e=fp_in[62:52]`, `f=fp_in[51:0]`.
  - Single: `e=fp_in[30:23]`, `f={fp_in[22:0],29'b0}`.
- Load rules by operand class:
  - Normal: `ea=e`, `fa={1,f}`.
  - Denormal (e=0, f≠0): `ea=1` (emin), `fa={0,f}`, `denorm`=1.
  - Zero: `ea=0`, `fa=0`, `zero`=1.
  - Inf/NaN (e all ones for the format): `ea=e`, `fa={1,f}`. `nan` is set when f≠0. `snan` is set when f≠0 and the fraction MSB is 0.
  - `lz` is loaded as 0 in every case.
- NORM, one of three actions per cycle:
  - If `fa[52]`=1, or `zero`, `inf` or `nan` is set: go to DONE.
  - Else if `fa[52:45]`=0: `fa<<=8`, `lz+=8`.
  - Else: `fa<<=1`, `lz+=1`.
- `ea` is never modified by NORM. The consumer forms the true exponent as `ea - lz`.
- DONE: `out_valid`=1 and all outputs are stable. On `out_ready` go to IDLE. Back-to-back operation is not overlapped.
- `lz` never exceeds 52. The width is 6 bits and there is no wrap.
- `in_valid` while not in IDLE is ignored: `in_ready`=0 and the operand is not captured.

## Timing
- Reset, asynchronous:
  - State goes to IDLE.
  - `in_ready`=1.
  - `out_valid`=0.
  - `sa`, `ea`, `fa`, `lz` and all flags are 0.
- Reset mid-NORM or mid-DONE aborts the operation and the result is discarded.
- Accept at edge k:
  - Normal, zero or special operand: NORM during cycle k+1, `out_valid` from k+2.
  - Denormal needing `s` shift cycles: `out_valid` from k+2+s.
- Worst case is double `f`=1: 6 coarse steps plus 4 single steps, so `out_valid` is asserted at k+12.
- `out_valid` holds, with outputs frozen, through any number of `out_ready`=0 cycles.
- `in_ready` returns high the cycle after the output handshake.

## Structure
- Package `fpu_unpack_pkg` holds:
  - the state enum;
  - `EMAX_DB`=11'h7FF and `EMAX_SP`=8'hFF;
  - `EMIN`=11'd1;
  - `FA_W`=53 and the single-precision pad width of 29.
- Sub-module `fp_classify`, purely combinational:
  - inputs: `fp_in`, `db`;
  - outputs: `e`, `f` (mapped to double width) and the five class flags.
- The top level holds the FSM, the shift/count datapath and the handshake.

## Test plan
- Double 1.0, `64'h3FF0_0000_0000_0000`, `out_ready`=1 → `out_valid` at k+2. `sa`=0, `ea`=11'h3FF, `fa`=53'h10_0000_0000_0000, `lz`=0, all flags 0.
- Double min denormal, `64'h0000_0000_0000_0001` → `out_valid` at k+12. `ea`=1, `lz`=52, `fa[52]`=1 with all other `fa` bits 0, `denorm`=1.
- Single denormal `32'h0000_0001`, `db`=0 → `ea`=1, `lz`=23, `fa[52]`=1 with all other `fa` bits 0, `out_valid` at k+11.
- Single sNaN `32'h7F80_0001` → `nan`=1, `snan`=1, `ea`=11'h0FF, `lz`=0. Single qNaN `32'h7FC0_0000` → `nan`=1, `snan`=0.
- Double −0, `64'h8000_0000_0000_0000`, with `out_ready` held low for 5 cycles → `out_valid` stays high with `sa`=1, `zero`=1, `fa`=0. `in_ready` stays 0 and a competing `in_valid` is ignored. `in_ready`=1 the cycle after `out_ready`.
- Start a double `f`=1 denormal and assert `rst_n`=0 at k+5 → outputs 0, `in_ready`=1, `out_valid`=0 immediately. A subsequent 1.0 operand completes normally.
